// File: rtl/data_sram_ctrl_pkg.sv
// Shared definitions for the data-side SRAM controller: access-size codes,
// FSM states, default wait count and the alignment check.
package data_sram_ctrl_pkg;

  localparam int unsigned WAIT_CYCLES_DEFAULT = 2;

  typedef enum logic [1:0] {
    SEL_WORD = 2'b00,
    SEL_HALF = 2'b01,
    SEL_BYTE = 2'b10,
    SEL_RSVD = 2'b11
  } sel_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE
  } state_t;

  // True when the access cannot be issued: misaligned word/halfword or reserved size.
  function automatic logic access_bad(input sel_t s, input logic [1:0] a);
    case (s)
      SEL_WORD: return a != 2'b00;
      SEL_HALF: return a[0];
      SEL_BYTE: return 1'b0;
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/data_sram_ctrl_lane.sv
// Byte-lane logic: byte-enable generation, store data alignment and
// load data extraction with zero/sign extension.
module sram_lane
  import data_sram_ctrl_pkg::*;
(
  input  sel_t        sel,
  input  logic [1:0]  addr_lo,
  input  logic        signed_ld,
  input  logic [31:0] wdata,
  input  logic [31:0] din,
  output logic [3:0]  be_n,
  output logic [31:0] wdata_al,
  output logic [31:0] rdata_ext
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Lane selection for all access sizes; reserved size leaves every lane disabled.
  always_comb begin
    be_n      = '1;
    wdata_al  = wdata;
    rdata_ext = din;
    case (addr_lo)
      2'd0:    rbyte = din[7:0];
      2'd1:    rbyte = din[15:8];
      2'd2:    rbyte = din[23:16];
      default: rbyte = din[31:24];
    endcase
    rhalf = addr_lo[1] ? din[31:16] : din[15:0];
    case (sel)
      SEL_WORD: be_n = 4'b0000;
      SEL_HALF: begin
        be_n      = addr_lo[1] ? 4'b0011 : 4'b1100;
        wdata_al  = {2{wdata[15:0]}};
        rdata_ext = {{16{signed_ld & rhalf[15]}}, rhalf};
      end
      SEL_BYTE: begin
        be_n      = ~(4'b0001 << addr_lo);
        wdata_al  = {4{wdata[7:0]}};
        rdata_ext = {{24{signed_ld & rbyte[7]}}, rbyte};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_sram_ctrl.sv
// CPU data-port to asynchronous SRAM controller: one access at a time,
// SETUP / ACCESS (WAIT_CYCLES) / DONE strobe sequence, early error completion.
module data_sram_ctrl
  import data_sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT,
  parameter int unsigned SRAM_AW     = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic               we,
  input  logic [1:0]         sel,
  input  logic               signed_ld,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic               ready,
  output logic               err,
  output logic [31:0]        rdata,
  output logic               busy,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [3:0]         sram_be_n,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [31:0]        sram_dout,
  output logic               sram_doe,
  input  logic [31:0]        sram_din
);

  state_t             state, state_nx;
  logic [2:0]         cnt;
  logic               t_we, t_signed, t_err;
  sel_t               t_sel;
  logic [SRAM_AW+1:0] t_addr;
  logic [31:0]        t_wdata;
  logic               bad_in;
  logic               strobe;
  logic [3:0]         lane_be_n;
  logic [31:0]        lane_wdata, lane_rdata;
  logic               unused_addr_hi;

  assign bad_in         = access_bad(sel_t'(sel), addr[1:0]);
  assign unused_addr_hi = ^addr[31:SRAM_AW+2];

  sram_lane u_lane (
    .sel       (t_sel),
    .addr_lo   (t_addr[1:0]),
    .signed_ld (t_signed),
    .wdata     (t_wdata),
    .din       (sram_din),
    .be_n      (lane_be_n),
    .wdata_al  (lane_wdata),
    .rdata_ext (lane_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // ACCESS-phase down-counter, loaded during SETUP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                cnt <= '0;
    else if (state == ST_SETUP)              cnt <= 3'(WAIT_CYCLES - 1);
    else if (state == ST_ACCESS && cnt != 0) cnt <= cnt - 3'd1;
  end

  // Transaction capture on acceptance; later input changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t_we     <= 1'b0;
      t_signed <= 1'b0;
      t_err    <= 1'b0;
      t_sel    <= SEL_WORD;
      t_addr   <= '0;
      t_wdata  <= '0;
    end else if (state == ST_IDLE && req) begin
      t_we     <= we;
      t_signed <= signed_ld;
      t_err    <= bad_in;
      t_sel    <= sel_t'(sel);
      t_addr   <= addr[SRAM_AW+1:0];
      t_wdata  <= wdata;
    end
  end

  // Load result, sampled on the final ACCESS edge only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                        rdata <= '0;
    else if (state == ST_ACCESS && cnt == 0 && !t_we) rdata <= lane_rdata;
  end

  // Next-state and strobe/handshake outputs.
  always_comb begin
    state_nx  = state;
    ready     = 1'b0;
    err       = 1'b0;
    busy      = (state != ST_IDLE);
    strobe    = 1'b0;
    sram_oe_n = 1'b1;
    sram_we_n = 1'b1;
    case (state)
      ST_IDLE:   if (req) state_nx = bad_in ? ST_DONE : ST_SETUP;
      ST_SETUP: begin
        strobe   = 1'b1;
        state_nx = ST_ACCESS;
      end
      ST_ACCESS: begin
        strobe    = 1'b1;
        sram_oe_n = t_we;
        sram_we_n = ~t_we;
        if (cnt == 0) state_nx = ST_DONE;
      end
      ST_DONE: begin
        // Stores keep chip select and data driven one more cycle for hold time.
        strobe   = t_we & ~t_err;
        ready    = 1'b1;
        err      = t_err;
        state_nx = ST_IDLE;
      end
      default:   state_nx = ST_IDLE;
    endcase
    sram_ce_n = ~strobe;
    sram_be_n = strobe ? lane_be_n : '1;
    sram_doe  = strobe & t_we;
    sram_dout = sram_doe ? lane_wdata : '0;
    sram_addr = t_addr[SRAM_AW+1:2];
  end

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Directed bench for data_sram_ctrl: vector table of single accesses plus
// back-to-back and mid-access reset sequences.
module tb_data_sram_ctrl;
  import data_sram_ctrl_pkg::*;

  localparam int unsigned W  = 2;
  localparam int unsigned AW = 20;

  logic          clk = 1'b0;
  logic          rst, req, we, signed_ld;
  logic [1:0]    sel;
  logic [31:0]   addr, wdata, sram_din;
  logic          ready, err, busy;
  logic [31:0]   rdata, sram_dout;
  logic [AW-1:0] sram_addr;
  logic [3:0]    sram_be_n;
  logic          sram_ce_n, sram_oe_n, sram_we_n, sram_doe;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic [1:0]  sel;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] din;
    logic [3:0]  be_n;
    logic [31:0] dout;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[13];
  vec_t post;

  data_sram_ctrl #(.WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .sel(sel), .signed_ld(signed_ld),
    .addr(addr), .wdata(wdata), .ready(ready), .err(err), .rdata(rdata), .busy(busy),
    .sram_addr(sram_addr), .sram_be_n(sram_be_n), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_dout(sram_dout),
    .sram_doe(sram_doe), .sram_din(sram_din)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus-contention watch on every cycle outside reset.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      total++;
      if ((!sram_oe_n && !sram_we_n) || (!sram_oe_n && sram_doe)) begin
        bad++;
        $display("FAIL contention: oe_n=%b we_n=%b doe=%b required no overlap", sram_oe_n, sram_we_n, sram_doe);
      end
    end
  end

  function automatic vec_t mk(input logic w, input logic [1:0] s, input logic g,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] d,
                              input logic [3:0] be, input logic [31:0] dq,
                              input logic [31:0] rd, input logic e);
    vec_t v;
    v.we = w; v.sel = s; v.sgn = g; v.addr = a; v.wdata = wd; v.din = d;
    v.be_n = be; v.dout = dq; v.rdata = rd; v.err = e;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int n = 1;
    int oe_c = 0, we_c = 0, doe_c = 0;
    logic seen = 1'b0;
    logic [3:0] be1 = '1;
    logic [AW-1:0] a1 = '0;
    logic [31:0] d1 = '0;
    logic ce1 = 1'b1, busy1 = 1'b0, err_r = 1'b0;
    logic [31:0] rd_r = '0;
    logic [AW+1:0] va;
    @(negedge clk);
    req = 1'b1; we = v.we; sel = v.sel; signed_ld = v.sgn;
    addr = v.addr; wdata = v.wdata; sram_din = v.din;
    @(posedge clk); #1;
    req = 1'b0; we = ~v.we; sel = ~v.sel; signed_ld = ~v.sgn;
    addr = ~v.addr; wdata = ~v.wdata;
    while (!seen && n <= 20) begin
      if (n == 1) begin
        be1 = sram_be_n; a1 = sram_addr; d1 = sram_dout; ce1 = sram_ce_n; busy1 = busy;
      end
      if (!sram_oe_n) oe_c++;
      if (!sram_we_n) we_c++;
      if (sram_doe)   doe_c++;
      if (ready) begin
        seen = 1'b1; err_r = err; rd_r = rdata;
      end else begin
        @(posedge clk); #1;
        n++;
      end
    end
    if (!seen) begin
      check({tag, ".ready_timeout"}, 32'(ready), 32'd1);
      return;
    end
    va = v.addr[AW+1:0];
    check({tag, ".latency"}, n, v.err ? 1 : W + 2);
    check({tag, ".err"},     32'(err_r), 32'(v.err));
    check({tag, ".rdata"},   rd_r, v.rdata);
    check({tag, ".be_n"},    32'(be1), 32'(v.be_n));
    check({tag, ".ce_n"},    32'(ce1), 32'(v.err));
    check({tag, ".busy"},    32'(busy1), 32'd1);
    check({tag, ".oe_cycles"},  oe_c,  (!v.we && !v.err) ? W : 0);
    check({tag, ".we_cycles"},  we_c,  (v.we && !v.err) ? W : 0);
    check({tag, ".doe_cycles"}, doe_c, (v.we && !v.err) ? W + 2 : 0);
    if (!v.err) check({tag, ".sram_addr"}, 32'(a1), 32'(va[AW+1:2]));
    if (v.we && !v.err) check({tag, ".dout"}, d1, v.dout);
    @(posedge clk); #1;
    check({tag, ".rdata_hold"}, rdata, v.rdata);
    check({tag, ".idle_busy"},  32'(busy), 32'd0);
  endtask

  initial begin
    int r = 0, gap = 0;
    rst = 1'b0; req = 1'b0; we = 1'b0; sel = 2'b00; signed_ld = 1'b0;
    addr = '0; wdata = '0; sram_din = '0;

    //        we    sel    sgn  addr          wdata         din           be_n     dout          rdata         err
    vecs[0]  = mk(1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0,        32'h89AB_CDEF, 4'b0000, 32'h0,        32'h89AB_CDEF, 1'b0);
    vecs[1]  = mk(1'b0, 2'b10, 1'b1, 32'h0000_0013, 32'h0,        32'h80FF_7F01, 4'b0111, 32'h0,        32'hFFFF_FF80, 1'b0);
    vecs[2]  = mk(1'b0, 2'b10, 1'b0, 32'h0000_0013, 32'h0,        32'h80FF_7F01, 4'b0111, 32'h0,        32'h0000_0080, 1'b0);
    vecs[3]  = mk(1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h0000_BEEF, 32'hFFFF_FFFF, 4'b0011, 32'hBEEF_BEEF, 32'h0000_0080, 1'b0);
    vecs[4]  = mk(1'b0, 2'b00, 1'b0, 32'h0000_0001, 32'h0,        32'hFFFF_FFFF, 4'b1111, 32'h0,        32'h0000_0080, 1'b1);
    vecs[5]  = mk(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 4'b0011, 32'h0,        32'hFFFF_8001, 1'b0);
    vecs[6]  = mk(1'b0, 2'b01, 1'b0, 32'h0000_0100, 32'h0,        32'h1234_F00D, 4'b1100, 32'h0,        32'h0000_F00D, 1'b0);
    vecs[7]  = mk(1'b1, 2'b10, 1'b0, 32'h0000_0201, 32'hFFFF_FF5A, 32'hFFFF_FFFF, 4'b1101, 32'h5A5A_5A5A, 32'h0000_F00D, 1'b0);
    vecs[8]  = mk(1'b0, 2'b11, 1'b0, 32'h0000_0040, 32'h0,        32'hFFFF_FFFF, 4'b1111, 32'h0,        32'h0000_F00D, 1'b1);
    vecs[9]  = mk(1'b1, 2'b01, 1'b0, 32'h0000_0003, 32'h1234_5678, 32'hFFFF_FFFF, 4'b1111, 32'h0,        32'h0000_F00D, 1'b1);
    vecs[10] = mk(1'b1, 2'b00, 1'b0, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 4'b0000, 32'hDEAD_BEEF, 32'h0000_F00D, 1'b0);
    vecs[11] = mk(1'b0, 2'b10, 1'b1, 32'h0000_0000, 32'h0,        32'h0000_007F, 4'b1110, 32'h0,        32'h0000_007F, 1'b0);
    vecs[12] = mk(1'b0, 2'b10, 1'b1, 32'h0000_0005, 32'h0,        32'h0000_9A00, 4'b1101, 32'h0,        32'hFFFF_FF9A, 1'b0);
    post     = mk(1'b0, 2'b00, 1'b0, 32'h0000_0044, 32'h0,        32'h0BAD_CAFE, 4'b0000, 32'h0,        32'h0BAD_CAFE, 1'b0);

    // Reset values.
    #12;
    check("rst.ready",     32'(ready), 32'd0);
    check("rst.busy",      32'(busy), 32'd0);
    check("rst.rdata",     rdata, 32'h0);
    check("rst.strobes",   32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'h7);
    check("rst.be_n",      32'(sram_be_n), 32'hF);
    check("rst.doe",       32'(sram_doe), 32'd0);
    check("rst.sram_addr", 32'(sram_addr), 32'h0);
    check("rst.dout",      sram_dout, 32'h0);
    @(negedge clk); rst = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

    // Back-to-back loads with req held: one idle cycle between DONE and SETUP.
    @(negedge clk);
    req = 1'b1; we = 1'b0; sel = 2'b00; signed_ld = 1'b0;
    addr = 32'h0000_0010; sram_din = 32'h1122_3344;
    for (int c = 0; c < 30 && r < 2; c++) begin
      @(posedge clk); #1;
      if (r == 1 && !busy) gap++;
      if (ready) r++;
    end
    req = 1'b0;
    check("b2b.ready_count", r, 2);
    check("b2b.idle_gap",    gap, 1);
    check("b2b.rdata",       rdata, 32'h1122_3344);
    @(posedge clk); #1;

    // Reset in the middle of ACCESS aborts without a ready pulse.
    @(negedge clk);
    req = 1'b1; we = 1'b0; sel = 2'b00; addr = 32'h0000_0020; sram_din = 32'hCAFE_F00D;
    @(posedge clk); #1; req = 1'b0;
    @(posedge clk); #1;
    check("mid.in_access_oe_n", 32'(sram_oe_n), 32'd0);
    #1 rst = 1'b0;
    #1;
    check("mid.strobes",   32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'h7);
    check("mid.be_n",      32'(sram_be_n), 32'hF);
    check("mid.ready",     32'(ready), 32'd0);
    check("mid.busy",      32'(busy), 32'd0);
    check("mid.rdata",     rdata, 32'h0);
    check("mid.sram_addr", 32'(sram_addr), 32'h0);
    @(posedge clk); #1;
    check("mid.ready_after", 32'(ready), 32'd0);
    @(negedge clk); rst = 1'b1;
    run_vec(post, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_sram_ctrl.md
DATA_SRAM_CTRL -- requirements
Module: data_sram_ctrl

Interface
REQ-001 SHALL have parameter: WAIT_CYCLES, 2, SRAM strobe-active cycles per access (1..7).
REQ-002 SHALL have parameter: SRAM_AW, 20, SRAM word-address width.
REQ-003 SHALL have port: clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: req  input  1  CPU data-access request, held until ready.
REQ-006 SHALL have port: we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port: sel  input  2  access size: 00 word, 01 halfword, 10 byte, 11 reserved.
REQ-008 SHALL have port: signed_ld  input  1  sign-extend halfword/byte loads.
REQ-009 SHALL have port: addr  input  32  byte address (alu result).
REQ-010 SHALL have port: wdata  input  32  store data, right-justified.
REQ-011 SHALL have port: ready  output  1  one-cycle completion pulse.
REQ-012 SHALL have port: err  output  1  misalignment/reserved flag, valid with ready.
REQ-013 SHALL have port: rdata  output  32  load result, valid with ready, held until next ready.
REQ-014 SHALL have port: busy  output  1  high from acceptance through ready cycle.
REQ-015 SHALL have ports: sram_addr output SRAM_AW; sram_be_n output 4; sram_ce_n, sram_oe_n, sram_we_n output 1 each; sram_dout output 32; sram_doe output 1 (drive enable); sram_din input 32.

Function
REQ-016 SHALL implement FSM IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
REQ-017 IDLE: SHALL accept when req=1; register we, sel, signed_ld, addr, wdata; go SETUP.
REQ-018 Misaligned (word addr[1:0]!=0, halfword addr[0]=1) or sel=11: SHALL go IDLE->DONE directly, no SRAM strobe, err=1 with ready.
REQ-019 SETUP (1 cycle): sram_ce_n=0, sram_addr=addr[SRAM_AW+1:2], sram_be_n valid; stores also sram_doe=1, sram_dout=lane-aligned wdata.
REQ-020 ACCESS: SHALL last exactly WAIT_CYCLES cycles via down-counter; loads sram_oe_n=0, stores sram_we_n=0.
REQ-021 Load: sram_din SHALL be captured on the last ACCESS edge; extracted lane zero- or sign-extended per signed_ld into rdata.
REQ-022 DONE (1 cycle): ready=1; strobes high; stores keep sram_doe=1, sram_ce_n=0 for hold time; go IDLE.
REQ-023 Latency: ready SHALL assert WAIT_CYCLES+2 cycles after acceptance edge; misaligned: 1 cycle.
REQ-024 Byte lanes: byte -> be_n bit addr[1:0] low; halfword -> lanes {addr[1],0} pair low; word -> all low; be_n=1111 when idle.
REQ-025 req high in DONE SHALL NOT be accepted; re-accepted from IDLE next cycle (one idle cycle between back-to-back accesses).
REQ-026 Input changes after acceptance SHALL have no effect on current transaction.
REQ-027 sram_oe_n and sram_we_n SHALL never be low together; sram_doe SHALL be 0 whenever sram_oe_n=0.
REQ-028 rdata SHALL be unchanged by stores and error completions.

Reset
REQ-029 rst=0 SHALL immediately force: state IDLE, counter 0, ready=0, err=0, busy=0, rdata=0, sram_ce_n/oe_n/we_n=1, sram_be_n=1111, sram_doe=0, sram_addr=0, sram_dout=0.
REQ-030 Reset mid-transaction SHALL abort with no ready pulse; first accept SHALL occur on first edge with rst=1 and req=1.

Structure
REQ-031 Shared package SHALL hold sel encodings, FSM state enum, WAIT_CYCLES default.
REQ-032 Lane logic (be_n generation, write alignment, read extraction/extension) SHALL be combinational sub-module sram_lane.

Verification
REQ-033 Word load addr=0x00000010, sram_din=0x89ABCDEF, WAIT_CYCLES=2 -> sram_addr=0x4, oe_n low 2 cycles, ready 4 cycles after accept, rdata=0x89ABCDEF.
REQ-034 Signed byte load addr=0x...13, din=0x80FF7F01 -> be_n=0111, rdata=0xFFFFFF80; unsigned -> 0x00000080.
REQ-035 Halfword store addr=0x...22, wdata=0x0000BEEF -> be_n=0011, sram_dout[31:16]=0xBEEF, we_n low 2 cycles, doe high through DONE.
REQ-036 Word load addr=0x...01 -> no strobe, ready+err next cycle, rdata unchanged.
REQ-037 Reset asserted during ACCESS -> strobes high same cycle, no ready; post-reset load completes normally.
REQ-038 req held high over two loads -> exactly one IDLE cycle between DONE and next SETUP; oe_n/we_n never both low.
